// File: rtl/bydin_src_param.sv
// Scanned-frame data source: a row/column address generator with fixed-latency read data, plus a periodic interrupt.
// Define BYDIN_LONG_PERIOD_EN to use the fixed 1 s interrupt period (40 MHz clk) instead of INT_PERIOD.
module bydin_src_param #(
  parameter int          DW         = 8,
  parameter int          MI_DEPTH   = 72,
  parameter int          K_DEPTH    = 224,
  parameter int          ROW_STRIDE = 240,
  parameter int          RD_LAT     = 4,
  parameter logic [21:0] INT_PERIOD = 22'h200
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_rd_ena,
  input  logic          scan_mode,
  output logic [DW-1:0] mem_data_out,
  output logic          mem_ena_out,
  output logic          frame_done,
  output logic          bydin_int
);

`ifdef BYDIN_LONG_PERIOD_EN
  localparam logic [21:0] PERIOD = 22'h2625A0;
`else
  localparam logic [21:0] PERIOD = INT_PERIOD;
`endif

  localparam int         PL      = RD_LAT - 1;
  localparam logic [8:0] ROW_MAX = 9'(MI_DEPTH - 1);
  localparam logic [7:0] COL_MAX = 8'(K_DEPTH - 1);

  logic [8:0]  row;
  logic [7:0]  col;
  logic        mode_q;
  logic        at_start;
  logic        cur_mode;
  logic        row_last;
  logic        col_last;
  logic [16:0] addr_c;

  logic          a_v;
  logic          a_last;
  logic [16:0]   a_addr;
  logic [DW-1:0] data_c;
  logic          unused_addr_bit;

  logic          pipe_v    [PL];
  logic          pipe_last [PL];
  logic [DW-1:0] pipe_d    [PL];

  logic [3:0]  prescale;
  logic        tick;
  logic [21:0] tick_cnt;

  assign at_start = (row == 9'd0) && (col == 8'd0);
  assign row_last = (row == ROW_MAX);
  assign col_last = (col == COL_MAX);
  // Scan order is only re-read at frame start, so a mid-frame change waits for the wrap.
  assign cur_mode = at_start ? scan_mode : mode_q;
  assign addr_c   = 17'(row) * 17'(ROW_STRIDE) + 17'(col);

  // NOTE: sequential state is always updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row    <= '0;
      col    <= '0;
      mode_q <= 1'b0;
    end else if (mem_rd_ena) begin
      if (at_start) mode_q <= scan_mode;
      if (!cur_mode) begin
        if (row_last) begin
          row <= '0;
          col <= col_last ? 8'd0 : col + 8'd1;
        end else begin
          row <= row + 9'd1;
        end
      end else begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? 9'd0 : row + 9'd1;
        end else begin
          col <= col + 8'd1;
        end
      end
    end
  end

  // Address stage: captures the pre-increment counters of the accepted request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_v    <= 1'b0;
      a_last <= 1'b0;
      a_addr <= '0;
    end else begin
      a_v    <= mem_rd_ena;
      a_last <= mem_rd_ena && row_last && col_last;
      if (mem_rd_ena) a_addr <= addr_c;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    data_c      = '0;
    data_c[7:0] = a_addr[16:9] ^ a_addr[7:0];
    for (int i = 8; i < DW; i++) data_c[i] = a_addr[i+1];
  end

  assign unused_addr_bit = a_addr[8];

  // NOTE: the pipeline arrays are reset too, so in-flight requests vanish on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PL; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_last[i] <= 1'b0;
        pipe_d[i]    <= '0;
      end
    end else begin
      pipe_v[0]    <= a_v;
      pipe_last[0] <= a_last;
      pipe_d[0]    <= data_c;
      for (int i = 1; i < PL; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_d[i]    <= pipe_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ena_out  <= 1'b0;
      frame_done   <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ena_out <= pipe_v[PL-1];
      frame_done  <= pipe_v[PL-1] && pipe_last[PL-1];
      if (pipe_v[PL-1]) mem_data_out <= pipe_d[PL-1];
    end
  end

  // Interrupt timebase: the prescaler wrap is a clock enable, never a derived clock.
  assign tick = (prescale == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale  <= '0;
      tick_cnt  <= '0;
      bydin_int <= 1'b0;
    end else begin
      prescale  <= prescale + 4'd1;
      bydin_int <= tick && (tick_cnt == PERIOD);
      if (tick) tick_cnt <= (tick_cnt == PERIOD) ? 22'd0 : tick_cnt + 22'd1;
    end
  end

endmodule

// File: tb/tb_bydin_src_param.sv
// Directed bench for bydin_src_param at default parameters: vector table plus multi-cycle sequences.
module tb_bydin_src_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_rd_ena = 1'b0;
  logic       scan_mode = 1'b0;
  logic [7:0] mem_data_out;
  logic       mem_ena_out;
  logic       frame_done;
  logic       bydin_int;

  int total = 0;
  int passed = 0;
  int stray_done = 0;

  logic [7:0] got_data[$];
  logic       got_done[$];

  typedef struct {
    logic       req;
    logic       exp_ena;
    logic [7:0] exp_data;
    logic       exp_done;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  bydin_src_param dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_rd_ena   (mem_rd_ena),
    .scan_mode    (scan_mode),
    .mem_data_out (mem_data_out),
    .mem_ena_out  (mem_ena_out),
    .frame_done   (frame_done),
    .bydin_int    (bydin_int)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    mem_rd_ena = 1'b0;
    scan_mode  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Element k of a frame at default geometry (72 rows, 224 cols, stride 240).
  function automatic logic [7:0] model(input int k, input logic mode);
    int row, col;
    logic [16:0] a;
    if (!mode) begin
      row = k % 72;
      col = (k / 72) % 224;
    end else begin
      col = k % 224;
      row = (k / 224) % 72;
    end
    a = 17'(row * 240 + col);
    return a[16:9] ^ a[7:0];
  endfunction

  // n back-to-back requests from cycle 0; scan_mode flips at toggle_at (-1 = never).
  task automatic stream(input int n, input logic mode, input int toggle_at, output int first_lat);
    got_data.delete();
    got_done.delete();
    first_lat = -1;
    for (int c = 0; c < n + 6; c++) begin
      @(negedge clk);
      mem_rd_ena = (c < n);
      if (c == 0) scan_mode = mode;
      if (c == toggle_at) scan_mode = ~scan_mode;
      @(posedge clk);
      #1;
      if (mem_ena_out) begin
        if (first_lat < 0) first_lat = c;
        got_data.push_back(mem_data_out);
        got_done.push_back(frame_done);
      end else if (frame_done) begin
        stray_done++;
      end
    end
    @(negedge clk);
    mem_rd_ena = 1'b0;
  endtask

  initial begin
    int lat, errs, ndone, n;

    // Gapped pattern 1,0,1,1,0 in mode 0: addr 0, 240, 480 -> 0x00, 0xF0, 0xE0.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'hE0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'hE0, 1'b0};

    #1;
    check("reset_ena", mem_ena_out, 0);
    check("reset_data", mem_data_out, 0);
    check("reset_done", frame_done, 0);
    check("reset_int", bydin_int, 0);

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      mem_rd_ena = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ena", i), mem_ena_out, vecs[i].exp_ena);
      check($sformatf("vec%0d_data", i), mem_data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_done", i), frame_done, vecs[i].exp_done);
    end

    // 73 back-to-back requests in mode 0: the 73rd wraps row and steps column.
    do_reset();
    stream(73, 1'b0, -1, lat);
    check("b2b_latency", lat, 4);
    check("b2b_count", got_data.size(), 73);
    if (got_data.size() == 73) begin
      check("b2b_elem1", got_data[0], 8'h00);
      check("b2b_elem2", got_data[1], 8'hF0);
      check("b2b_elem73", got_data[72], 8'h01);
    end

    // Mode 1, with scan_mode flipped mid-frame: order must stay column-fastest.
    do_reset();
    stream(3, 1'b1, 2, lat);
    check("m1_count", got_data.size(), 3);
    if (got_data.size() == 3) begin
      check("m1_elem1", got_data[0], 8'h00);
      check("m1_elem2", got_data[1], 8'h01);
      check("m1_elem3_after_toggle", got_data[2], 8'h02);
    end

    // Full mode-0 frame; toggle to mode 1 mid-frame takes effect only after the wrap.
    do_reset();
    stream(16130, 1'b0, 100, lat);
    check("frame_count", got_data.size(), 16130);
    if (got_data.size() == 16130) begin
      errs  = 0;
      ndone = 0;
      for (int k = 0; k < 16128; k++) if (got_data[k] !== model(k, 1'b0)) errs++;
      foreach (got_done[k]) if (got_done[k]) ndone++;
      check("frame_data_errors", errs, 0);
      check("frame_last_data", got_data[16127], 8'h4E);
      check("frame_done_on_last", got_done[16127], 1);
      check("frame_done_count", ndone, 1);
      check("frame_next_elem", got_data[16128], 8'h00);
      check("frame_mode1_after_wrap", got_data[16129], model(1, 1'b1));
    end
    check("stray_frame_done", stray_done, 0);

    // Reset with 3 requests in flight: nothing may emerge afterwards.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rd_ena = 1'b1;
    end
    @(negedge clk);
    mem_rd_ena = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("midreset_ena", mem_ena_out, 0);
    check("midreset_data", mem_data_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (mem_ena_out) n++;
    end
    check("post_reset_no_ena", n, 0);
    stream(1, 1'b0, -1, lat);
    check("post_reset_count", got_data.size(), 1);
    if (got_data.size() == 1) check("post_reset_data", got_data[0], 8'h00);
    check("post_reset_latency", lat, 4);

    // Interrupt: 16*(0x200+1) = 8208 cycles after release, then every 8208 cycles.
    do_reset();
    n = 0;
    for (int c = 1; c <= 9000; c++) begin
      @(posedge clk);
      #1;
      if (bydin_int) begin
        n = c;
        break;
      end
    end
    check("int_first", n, 8208);
    @(posedge clk);
    #1;
    check("int_width", bydin_int, 0);
    n = 0;
    for (int c = 2; c <= 9000; c++) begin
      @(posedge clk);
      #1;
      if (bydin_int) begin
        n = c;
        break;
      end
    end
    check("int_period", n, 8208);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bydin_src_param.md
BYDIN_SRC_PARAM -- requirements
Module: bydin_src_param

Interface
REQ-001 Parameter DW, default 8: output data width, 8..16.
REQ-002 Parameter MI_DEPTH, default 72: rows per frame, 1..511.
REQ-003 Parameter K_DEPTH, default 224: columns per frame, 1..255.
REQ-004 Parameter ROW_STRIDE, default 240: address increment per row; must be >= K_DEPTH.
REQ-005 Parameter RD_LAT, default 4: read latency in cycles, 2..8.
REQ-006 Parameter INT_PERIOD, default 22'h200: interrupt period in prescaler ticks.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 mem_rd_ena  input  1  one element is requested in each cycle this is high.
REQ-010 scan_mode  input  1  scan order: 0 = row-major (row fastest), 1 = column-major (column fastest).
REQ-011 mem_data_out  output  DW  data of the element being returned.
REQ-012 mem_ena_out  output  1  qualifies mem_data_out.
REQ-013 frame_done  output  1  one-cycle pulse with the last element of a frame.
REQ-014 bydin_int  output  1  one-cycle periodic interrupt pulse.

Function
REQ-015 Row counter shall be 9 bits, range 0..MI_DEPTH-1; column counter shall be 8 bits, range 0..K_DEPTH-1.
REQ-016 Mode 0: row shall advance on each request; column shall advance when row wraps from MI_DEPTH-1 to 0.
REQ-017 Mode 1: column shall advance on each request; row shall advance when column wraps from K_DEPTH-1 to 0.
REQ-018 Frame end (row=MI_DEPTH-1, col=K_DEPTH-1, request) shall wrap both counters to 0.
REQ-019 Address shall be 17 bits: row*ROW_STRIDE + col, computed from the pre-increment counters and truncated to 17 bits.
REQ-020 Data shall be (addr[16:9] XOR addr[7:0]), zero-extended to DW; when DW>8, bits DW-1:8 shall be addr[DW:9] XOR 0.
REQ-021 mem_ena_out and the matching mem_data_out shall appear exactly RD_LAT cycles after the clock edge that samples mem_rd_ena high, always aligned with each other.
REQ-022 Back-to-back requests shall produce back-to-back outputs; gaps in requests shall be preserved in the output.
REQ-023 mem_data_out shall hold its last value while mem_ena_out is low.
REQ-024 frame_done shall be high in the same cycle as mem_ena_out for the frame-end element.
REQ-025 scan_mode shall be sampled only when both counters are 0 and a request is accepted; a change mid-frame shall take effect at the next frame start.
REQ-026 Prescaler shall be a 4-bit free-running counter; its wrap shall generate a one-cycle tick enable (no derived clock).
REQ-027 Tick counter shall be 22 bits; on a tick, it shall clear at PERIOD and otherwise increment.
REQ-028 bydin_int shall pulse for exactly one clk cycle on the tick at which the count equals PERIOD; period = 16*(PERIOD+1) clk cycles.

Reset
REQ-029 Reset shall asynchronously clear: counters, address, pipeline, prescaler, tick counter and latched scan_mode (to 0).
REQ-030 Outputs mem_data_out, mem_ena_out, frame_done and bydin_int shall be 0 during reset.
REQ-031 Requests in flight at reset assertion shall be discarded; the first request after release shall return addr 0.

Configuration
REQ-032 Macro BYDIN_LONG_PERIOD_EN shall select the interrupt period.
- Defined: PERIOD = 22'h2625A0 (1 s at 40 MHz clk).
- Undefined: PERIOD = INT_PERIOD.

Verification
REQ-033 Defaults, mode 0, 73 back-to-back requests -> element 1 = 0x00 (addr 0), element 2 = 0xF0 (addr 240), element 73 = 0x01 (row 0, col 1); each element RD_LAT=4 cycles after its request.
REQ-034 Mode 0, full frame of 16128 continuous requests -> last data 0x4E (addr 0x436F); frame_done high with it only; next element = 0x00.
REQ-035 Request pattern 1,0,1,1,0 -> mem_ena_out pattern 1,0,1,1,0 delayed 4 cycles; data held during gaps.
REQ-036 Mode 1, 2 requests -> data 0x00 then 0x01; toggle scan_mode mid-frame -> order unchanged until frame wrap.
REQ-037 Macro undefined -> first bydin_int pulse 8208 cycles after reset release; subsequent pulses every 8208 cycles, each one cycle wide.
REQ-038 Assert reset_n low mid-stream with 3 requests in flight -> no mem_ena_out after release; next request returns 0x00.
